// File: rtl/dmem_rd_assembler.sv
// Gathers LANE_W-bit memory beats into one DATA_W-bit load result, with sized access,
// zero/sign extension and selectable lane order. The block restarts on any start, even mid-load.
//
// state  | meaning
// S_IDLE | no load in progress; out_data holds the last result
// S_FILL | collecting beats; busy=1
module dmem_rd_assembler #(
  parameter int DATA_W     = 32,
  parameter int LANE_W     = 8,
  parameter bit BIG_ENDIAN = 1'b0,
  localparam int NLANES    = DATA_W / LANE_W,
  localparam int LG        = $clog2(NLANES),
  localparam int SZ_W      = (LG > 0) ? $clog2(LG + 1) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [SZ_W-1:0]   size,
  input  logic              sext,
  input  logic              in_valid,
  input  logic [LANE_W-1:0] in_data,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [DATA_W-1:0] out_data
);

  localparam int CNT_W = (LG > 0) ? LG : 1;
  localparam int BW    = LG + 1;

  typedef enum logic {S_IDLE, S_FILL} state_t;

  state_t              state_q;
  logic [CNT_W-1:0]    cnt_q;
  logic [BW-1:0]       beats_q;
  logic                sext_q;
  logic                busy_q;
  logic                done_q;
  logic                err_q;
  logic [DATA_W-1:0]   out_q;

  logic                size_bad;
  logic [BW-1:0]       beats_d;
  logic [CNT_W-1:0]    last_cnt;
  logic [CNT_W-1:0]    lane_idx;
  logic                is_last;
  logic [DATA_W-1:0]   lane_wr_d;
  logic [DATA_W-1:0]   ext_wr_d;
  logic                field_msb;

  assign size_bad = size > SZ_W'(LG);
  assign beats_d  = BW'(1) << size;
  assign last_cnt = CNT_W'(beats_q - BW'(1));
  assign lane_idx = BIG_ENDIAN ? (last_cnt - cnt_q) : cnt_q;
  assign is_last  = (cnt_q == last_cnt);

  // Merge the incoming beat, then build the extended variant used on the final beat.
  always_comb begin
    lane_wr_d = out_q;
    for (int l = 0; l < NLANES; l++) begin
      if (CNT_W'(l) == lane_idx) lane_wr_d[l*LANE_W +: LANE_W] = in_data;
    end
    field_msb = 1'b0;
    for (int l = 0; l < NLANES; l++) begin
      if (BW'(l) == beats_q - BW'(1)) field_msb = lane_wr_d[l*LANE_W + LANE_W - 1];
    end
    ext_wr_d = lane_wr_d;
    for (int l = 0; l < NLANES; l++) begin
      if (BW'(l) >= beats_q) ext_wr_d[l*LANE_W +: LANE_W] = {LANE_W{sext_q & field_msb}};
    end
  end

  // start outranks in_valid in every state, so a restart drops the beat presented with it.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      beats_q <= BW'(1);
      sext_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      out_q   <= '0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      if (start && size_bad) begin
        err_q   <= 1'b1;
        state_q <= S_IDLE;
        busy_q  <= 1'b0;
      end else if (start) begin
        state_q <= S_FILL;
        busy_q  <= 1'b1;
        sext_q  <= sext;
        beats_q <= beats_d;
        cnt_q   <= '0;
        out_q   <= '0;
      end else if (state_q == S_FILL && in_valid) begin
        if (is_last) begin
          out_q   <= ext_wr_d;
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
          cnt_q   <= '0;
        end else begin
          out_q <= lane_wr_d;
          cnt_q <= cnt_q + CNT_W'(1);
        end
      end
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign err      = err_q;
  assign out_data = out_q;

endmodule

// File: tb/tb_dmem_rd_assembler.sv
// Drives a little-endian and a big-endian assembler with shared stimulus; per-instance
// scoreboards hold hand-computed results that negedge monitors compare against done/err pulses.
module tb_dmem_rd_assembler;

  logic        clk = 1'b0;
  logic        rst, start, sext, in_valid;
  logic [1:0]  size;
  logic [7:0]  in_data;
  logic        busy_le, done_le, err_le, busy_be, done_be, err_be;
  logic [31:0] out_le, out_be;

  typedef struct packed {
    logic        is_err;
    logic [31:0] data;
  } exp_t;

  exp_t q_le[$];
  exp_t q_be[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  always #5 clk = ~clk;

  dmem_rd_assembler #(.DATA_W(32), .LANE_W(8), .BIG_ENDIAN(1'b0)) u_le (
    .clk(clk), .rst(rst), .start(start), .size(size), .sext(sext),
    .in_valid(in_valid), .in_data(in_data),
    .busy(busy_le), .done(done_le), .err(err_le), .out_data(out_le)
  );

  dmem_rd_assembler #(.DATA_W(32), .LANE_W(8), .BIG_ENDIAN(1'b1)) u_be (
    .clk(clk), .rst(rst), .start(start), .size(size), .sext(sext),
    .in_valid(in_valid), .in_data(in_data),
    .busy(busy_be), .done(done_be), .err(err_be), .out_data(out_be)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
  endtask

  always @(negedge clk) begin
    if (!rst && (done_le || err_le)) begin
      chk("le_done_err_exclusive", 32'(done_le & err_le), 32'd0);
      if (q_le.size() == 0) begin
        chk("le_unexpected_strobe", {30'd0, done_le, err_le}, 32'd0);
      end else begin
        exp_t e;
        e = q_le.pop_front();
        chk("le_strobe_kind", 32'(err_le), 32'(e.is_err));
        chk("le_out_data", out_le, e.data);
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && (done_be || err_be)) begin
      chk("be_done_err_exclusive", 32'(done_be & err_be), 32'd0);
      if (q_be.size() == 0) begin
        chk("be_unexpected_strobe", {30'd0, done_be, err_be}, 32'd0);
      end else begin
        exp_t e;
        e = q_be.pop_front();
        chk("be_strobe_kind", 32'(err_be), 32'(e.is_err));
        chk("be_out_data", out_be, e.data);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_res(input logic is_err, input logic [31:0] le, input logic [31:0] be);
    q_le.push_back('{is_err: is_err, data: le});
    q_be.push_back('{is_err: is_err, data: be});
  endtask

  task automatic issue(input logic [1:0] sz, input logic sx);
    start = 1'b1; size = sz; sext = sx; in_valid = 1'b0;
    step();
    start = 1'b0;
  endtask

  task automatic beat(input logic [7:0] d);
    in_valid = 1'b1; in_data = d;
    step();
    in_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; size = 2'd0; sext = 1'b0; in_valid = 1'b0; in_data = 8'd0;
    repeat (3) step();
    @(negedge clk);
    chk("reset_busy", 32'(busy_le | busy_be), 32'd0);
    chk("reset_strobes", {28'd0, done_le, err_le, done_be, err_be}, 32'd0);
    chk("reset_out_le", out_le, 32'd0);
    chk("reset_out_be", out_be, 32'd0);
    rst = 1'b0;
    step();

    // little-endian word
    expect_res(1'b0, 32'h1234_5678, 32'h7856_3412);
    issue(2'd2, 1'b0);
    @(negedge clk);
    chk("word_busy_high", 32'(busy_le), 32'd1);
    step();
    beat(8'h78); beat(8'h56); beat(8'h34); beat(8'h12);
    @(negedge clk);
    chk("word_busy_low", 32'(busy_le), 32'd0);
    step();

    // byte, sign-extended, back-to-back minimum latency
    expect_res(1'b0, 32'hFFFF_FF80, 32'hFFFF_FF80);
    issue(2'd0, 1'b1);
    beat(8'h80);
    @(negedge clk);
    chk("min_latency_done", 32'(done_le), 32'd1);
    step();
    @(negedge clk);
    chk("done_single_cycle", 32'(done_le), 32'd0);
    step();

    expect_res(1'b0, 32'h0000_0080, 32'h0000_0080);
    issue(2'd0, 1'b0);
    beat(8'h80);
    step();

    // halfword with a three-cycle stall
    expect_res(1'b0, 32'hFFFF_9234, 32'h0000_3492);
    issue(2'd1, 1'b1);
    beat(8'h34);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("stall_no_done", 32'(done_le | done_be), 32'd0);
      step();
    end
    beat(8'h92);
    step();

    expect_res(1'b0, 32'h7856_3412, 32'h1234_5678);
    issue(2'd2, 1'b0);
    beat(8'h12); beat(8'h34); beat(8'h56); beat(8'h78);
    step();

    expect_res(1'b0, 32'h0000_CDAB, 32'h0000_ABCD);
    issue(2'd1, 1'b0);
    beat(8'hAB); beat(8'hCD);
    step();

    // oversize request from IDLE leaves out_data alone
    expect_res(1'b1, 32'h0000_CDAB, 32'h0000_ABCD);
    issue(2'd3, 1'b0);
    @(negedge clk);
    chk("err_idle_busy", 32'(busy_le | busy_be), 32'd0);
    step();

    // restart mid-FILL; the beat presented with the restart is dropped
    expect_res(1'b0, 32'h0000_5544, 32'h0000_4455);
    issue(2'd2, 1'b1);
    beat(8'h11); beat(8'h22);
    start = 1'b1; size = 2'd1; sext = 1'b0; in_valid = 1'b1; in_data = 8'h99;
    step();
    start = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    chk("restart_busy", 32'(busy_le), 32'd1);
    step();
    beat(8'h44); beat(8'h55);
    step();

    // oversize restart mid-FILL aborts with partial data intact
    expect_res(1'b1, 32'h0000_0001, 32'h0100_0000);
    issue(2'd2, 1'b0);
    beat(8'h01);
    issue(2'd3, 1'b0);
    @(negedge clk);
    chk("err_fill_busy", 32'(busy_le | busy_be), 32'd0);
    step();

    // reset mid-load drops the transaction
    issue(2'd2, 1'b0);
    beat(8'hAA); beat(8'hBB);
    rst = 1'b1;
    step();
    @(negedge clk);
    chk("rst_mid_busy", 32'(busy_le | busy_be), 32'd0);
    chk("rst_mid_strobes", {28'd0, done_le, err_le, done_be, err_be}, 32'd0);
    chk("rst_mid_out", out_le | out_be, 32'd0);
    rst = 1'b0;
    step();

    expect_res(1'b0, 32'hDEAD_BEEF, 32'hEFBE_ADDE);
    issue(2'd2, 1'b0);
    beat(8'hEF); beat(8'hBE); beat(8'hAD); beat(8'hDE);
    repeat (5) step();

    chk("le_queue_drained", 32'(q_le.size()), 32'd0);
    chk("be_queue_drained", 32'(q_be.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
